// File: rtl/aiva_pkg.sv
// Shared opcode values and sequencer state encoding for the Aiva decoder.
package aiva_pkg;

  // Opcodes are an 8-bit set; wider opcode fields compare against the zero-extended value
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_LD   = 8'h02;
  localparam logic [7:0] OP_ST   = 8'h03;
  localparam logic [7:0] OP_JMP  = 8'h04;
  localparam logic [7:0] OP_WAIT = 8'h05;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } state_t;

endpackage

// File: rtl/decoder_seq_down_counter.sv
// Loadable saturating down-counter with a zero flag.
module down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count_q;

  // Load takes priority; decrement stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/decoder_seq.sv
// Multi-cycle instruction decoder/sequencer: decodes {op, rd, imm} and
// sequences memory, wait, jump and halt operations.
module decoder_seq
  import aiva_pkg::*;
#(
  parameter  int unsigned INSTR_W     = 24,
  parameter  int unsigned OP_W        = 8,
  parameter  int unsigned RD_W        = 4,
  parameter  int unsigned ADDR_W      = 12,
  parameter  int unsigned MEM_TIMEOUT = 15,
  localparam int unsigned IMM_W       = INSTR_W - OP_W - RD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_rdy,
  input  logic [INSTR_W-1:0] opcode,
  input  logic               mem_ack,
  output logic               pc_en,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_target,
  output logic               load_en,
  output logic [RD_W-1:0]    rd_sel,
  output logic [IMM_W-1:0]   imm,
  output logic               mem_req,
  output logic               mem_we,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic               bus_err
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t state_q, state_d;

  logic              done_q, done_d;
  logic              pc_load_d, load_en_d, illegal_d, bus_err_d;
  logic              mem_req_d, mem_we_d;
  logic [RD_W-1:0]   rd_sel_d;
  logic [IMM_W-1:0]  imm_d;
  logic [ADDR_W-1:0] pc_target_d;

  logic              wait_load, wait_dec, wait_zero_c;
  logic [IMM_W-1:0]  wait_val;
  logic              to_load, to_dec, to_zero_c;

  logic [OP_W-1:0]   op_f;
  logic [RD_W-1:0]   rd_f;
  logic [IMM_W-1:0]  imm_f;

  assign op_f  = opcode[INSTR_W-1 -: OP_W];
  assign rd_f  = opcode[INSTR_W-OP_W-1 -: RD_W];
  assign imm_f = opcode[IMM_W-1:0];

  // WAIT counter preloaded with imm-1 so completion lands imm cycles after decode
  assign wait_val = imm_f - IMM_W'(1);

  down_counter #(.W(IMM_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .dec      (wait_dec),
    .load_val (wait_val),
    .zero_c   (wait_zero_c)
  );

  // Timeout counter preloaded with MEM_TIMEOUT-1 so it expires after MEM_TIMEOUT request cycles
  down_counter #(.W(TO_W)) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .dec      (to_dec),
    .load_val (TO_W'(MEM_TIMEOUT - 1)),
    .zero_c   (to_zero_c)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      pc_load   <= 1'b0;
      load_en   <= 1'b0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      rd_sel    <= '0;
      imm       <= '0;
      pc_target <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      pc_load   <= pc_load_d;
      load_en   <= load_en_d;
      illegal   <= illegal_d;
      bus_err   <= bus_err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      rd_sel    <= rd_sel_d;
      imm       <= imm_d;
      pc_target <= pc_target_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    pc_load_d   = 1'b0;
    load_en_d   = 1'b0;
    illegal_d   = 1'b0;
    bus_err_d   = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    rd_sel_d    = rd_sel;
    imm_d       = imm;
    pc_target_d = pc_target;
    wait_load   = 1'b0;
    wait_dec    = 1'b0;
    to_load     = 1'b0;
    to_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (op_rdy) begin
          rd_sel_d = rd_f;
          imm_d    = imm_f;
          case (op_f)
            OP_W'(OP_NOP): begin
              done_d = 1'b1;
            end
            OP_W'(OP_LDI): begin
              load_en_d = 1'b1;
              done_d    = 1'b1;
            end
            OP_W'(OP_LD), OP_W'(OP_ST): begin
              state_d   = MEM;
              mem_req_d = 1'b1;
              mem_we_d  = (op_f == OP_W'(OP_ST));
              to_load   = 1'b1;
            end
            OP_W'(OP_JMP): begin
              pc_load_d   = 1'b1;
              pc_target_d = imm_f[ADDR_W-1:0];
            end
            OP_W'(OP_WAIT): begin
              if (imm_f == '0) begin
                done_d = 1'b1;
              end else begin
                state_d   = WAIT;
                wait_load = 1'b1;
              end
            end
            OP_W'(OP_HALT): begin
              state_d = HALT;
            end
            default: begin
              illegal_d = 1'b1;
              done_d    = 1'b1;
            end
          endcase
        end
      end

      MEM: begin
        // An ack on the expiry cycle still completes normally
        if (mem_ack) begin
          load_en_d = !mem_we;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end else if (to_zero_c) begin
          bus_err_d = 1'b1;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          to_dec = 1'b1;
        end
      end

      WAIT: begin
        if (wait_zero_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_dec = 1'b1;
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign halted = (state_q == HALT);

  // A jump cycle must not also advance the PC, so pc_load masks the idle term
  assign pc_en = done_q | ((state_q == IDLE) & !op_rdy & !pc_load);

endmodule
